bcd_display_formatter: RTL and testbench

//  Sequential binary-to-BCD converter with display formatting for the seven-segment driver.

---
 rtl/bcd_display_formatter.sv | 148 ++++++++++++++
 tb/tb_bcd_display_formatter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_formatter.sv
// Sequential double-dabble binary-to-BCD converter with display
// formatting (meter blanking, leading-zero blank, overflow, flash).
module bcd_display_formatter #(
  parameter int BIN_W       = 16,
  parameter int DIGITS      = 4,
  parameter int FLASH_DIV   = 50_000_000,
  parameter int BLANK_LIMIT = 200
) (
  input  logic                  SYS_CLK,
  input  logic                  SYS_RST_N,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [BIN_W-1:0]      In_Bin,
  input  logic [1:0]            In_Mode,
  output logic [4*DIGITS-1:0]   Out_BCD,
  output logic                  Out_Valid,
  output logic                  Out_Ovf
);

  // Digits for the full input range, plus DIGITS spare so the
  // overflow slice above the display is never empty.
  localparam int BCD_D = (BIN_W * 302) / 1000 + 1;
  localparam int NB    = BCD_D + DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam int FW    = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_FMT  = 2'd2;

  localparam logic [4*DIGITS-1:0] BLANK = {DIGITS{4'hA}};
  localparam logic [BIN_W:0]      BL    = (BIN_W + 1)'(BLANK_LIMIT);

  logic [1:0]          state;
  logic [BIN_W-1:0]    bin_q;
  logic [BIN_W-1:0]    sh_q;
  logic [1:0]          mode_q;
  logic [CW-1:0]       cnt_q;
  logic [4*NB-1:0]     bcd_q;
  logic [4*NB-1:0]     bcd_adj;
  logic [FW-1:0]       fcnt_q;
  logic                phase_q;
  logic                flash_q;
  logic [4*DIGITS-1:0] fmt_bcd;
  logic [4*DIGITS-1:0] low;
  logic                fmt_ovf;
  logic                fmt_flash;
  logic                lead;
  logic [3:0]          d;

  assign In_Ready = (state == S_IDLE);

  always_comb begin
    bcd_adj = '0;
    d       = '0;
    for (int i = 0; i < NB; i++) begin
      d = bcd_q[4*i +: 4];
      bcd_adj[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
  end

  always_comb begin
    low       = bcd_q[4*DIGITS-1:0];
    fmt_ovf   = |bcd_q[4*NB-1:4*DIGITS];
    fmt_bcd   = low;
    fmt_flash = 1'b0;
    lead      = 1'b1;
    if (fmt_ovf) begin
      fmt_bcd = '1;
    end else begin
      case (mode_q)
        2'd1: begin
          if (bin_q == '0) begin
            fmt_flash = 1'b1;
            fmt_bcd   = phase_q ? BLANK : '0;
          end else if (bin_q[0] && ({1'b0, bin_q} < BL)) begin
            fmt_bcd = BLANK;
          end
        end
        2'd2: begin
          for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && low[4*i +: 4] == 4'h0)
              fmt_bcd[4*i +: 4] = 4'hA;
            else
              lead = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RST_N) begin
      state     <= S_IDLE;
      bin_q     <= '0;
      sh_q      <= '0;
      mode_q    <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      fcnt_q    <= '0;
      phase_q   <= 1'b0;
      flash_q   <= 1'b0;
      Out_BCD   <= '0;
      Out_Valid <= 1'b0;
      Out_Ovf   <= 1'b0;
    end else begin
      Out_Valid <= 1'b0;
      if (fcnt_q == FW'(FLASH_DIV - 1)) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
      // A flashing result tracks the phase one edge after it toggles.
      if (flash_q)
        Out_BCD <= phase_q ? BLANK : '0;
      case (state)
        S_IDLE: begin
          if (In_Valid) begin
            bin_q  <= In_Bin;
            sh_q   <= In_Bin;
            mode_q <= In_Mode;
            bcd_q  <= '0;
            cnt_q  <= '0;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q <= {bcd_adj[4*NB-2:0], sh_q[BIN_W-1]};
          sh_q  <= sh_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_W - 1))
            state <= S_FMT;
        end
        S_FMT: begin
          Out_BCD   <= fmt_bcd;
          Out_Ovf   <= fmt_ovf;
          flash_q   <= fmt_flash;
          Out_Valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Directed bench for bcd_display_formatter
// (BIN_W=16, DIGITS=4, FLASH_DIV=4).
module tb_bcd_display_formatter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bin;
  logic [1:0]  in_mode;
  logic [15:0] out_bcd;
  logic        out_valid;
  logic        out_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_display_formatter #(
    .BIN_W(16), .DIGITS(4), .FLASH_DIV(4), .BLANK_LIMIT(200)
  ) dut (
    .SYS_CLK  (clk),
    .SYS_RST_N(rst_n),
    .In_Valid (in_valid),
    .In_Ready (in_ready),
    .In_Bin   (in_bin),
    .In_Mode  (in_mode),
    .Out_BCD  (out_bcd),
    .Out_Valid(out_valid),
    .Out_Ovf  (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input logic [15:0] got, input logic [15:0] exp,
                       input string tag);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] bin, input logic [1:0] mode);
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = bin;
    in_mode  = mode;
    tick();
    in_valid = 1'b0;
    in_bin   = 16'($urandom);
    in_mode  = 2'($urandom);
  endtask

  task automatic wait_result(inout int lat, input string tag);
    while (!out_valid && lat < 40) begin
      check(16'(in_ready), 16'd0, {tag, "_busy"});
      tick();
      lat++;
    end
    check(16'(lat), 16'd17, {tag, "_lat"});
  endtask

  task automatic run(input logic [15:0] bin, input logic [1:0] mode,
                     input logic [15:0] eb, input logic eo,
                     input string tag);
    int lat;
    accept(bin, mode);
    lat = 0;
    wait_result(lat, tag);
    check(out_bcd, eb, {tag, "_bcd"});
    check(16'(out_ovf), 16'(eo), {tag, "_ovf"});
    check(16'(in_ready), 16'd1, {tag, "_rdy"});
    tick();
    check(16'(out_valid), 16'd0, {tag, "_pulse"});
  endtask

  initial begin
    int lat;
    int since;
    int changes;
    int pulses;
    logic [15:0] prev;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bin   = '0;
    in_mode  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(out_bcd, 16'h0000, "rst_bcd");
    check(16'(out_valid), 16'd0, "rst_valid");
    check(16'(out_ovf), 16'd0, "rst_ovf");
    check(16'(in_ready), 16'd1, "rst_rdy");

    run(16'd1234,  2'd0, 16'h1234, 1'b0, "m0_1234");
    run(16'd199,   2'd1, 16'hAAAA, 1'b0, "m1_199");
    run(16'd200,   2'd1, 16'h0200, 1'b0, "m1_200");
    run(16'd201,   2'd1, 16'h0201, 1'b0, "m1_201");
    run(16'd7,     2'd1, 16'hAAAA, 1'b0, "m1_7");
    run(16'd42,    2'd2, 16'hAA42, 1'b0, "m2_42");
    run(16'd0,     2'd2, 16'hAAA0, 1'b0, "m2_0");
    run(16'd1004,  2'd2, 16'h1004, 1'b0, "m2_1004");
    run(16'd205,   2'd2, 16'hA205, 1'b0, "m2_205");
    run(16'd9999,  2'd0, 16'h9999, 1'b0, "m0_9999");
    run(16'd10000, 2'd0, 16'hFFFF, 1'b1, "m0_10000");
    run(16'd65535, 2'd2, 16'hFFFF, 1'b1, "m2_65535");
    run(16'd42,    2'd3, 16'h0042, 1'b0, "m3_42");
    run(16'd10001, 2'd1, 16'hFFFF, 1'b1, "m1_10001");
    run(16'd0,     2'd0, 16'h0000, 1'b0, "m0_0");

    // meter zero: flashes 0000/AAAA every 4 cycles, single pulse
    accept(16'd0, 2'd1);
    lat = 0;
    wait_result(lat, "flash");
    check(16'((out_bcd == 16'h0000) || (out_bcd == 16'hAAAA)), 16'd1,
          "flash_load");
    check(16'(out_ovf), 16'd0, "flash_ovf");
    prev    = out_bcd;
    since   = 0;
    changes = 0;
    pulses  = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      since++;
      if (out_valid) pulses++;
      if (out_bcd != prev) begin
        check(16'((out_bcd == 16'h0000) || (out_bcd == 16'hAAAA)), 16'd1,
              "flash_val");
        if (changes > 0) check(16'(since), 16'd4, "flash_period");
        changes++;
        since = 0;
        prev  = out_bcd;
      end
    end
    check(16'(pulses), 16'd0, "flash_pulses");
    check(16'(changes >= 5), 16'd1, "flash_changes");

    // new In_Valid while converting is ignored
    accept(16'd1234, 2'd0);
    lat = 0;
    repeat (3) begin tick(); lat++; end
    in_valid = 1'b1;
    in_bin   = 16'd5678;
    in_mode  = 2'd2;
    tick();
    lat++;
    in_valid = 1'b0;
    wait_result(lat, "ign");
    check(out_bcd, 16'h1234, "ign_bcd");
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check(16'(pulses), 16'd0, "ign_extra");

    // reset mid-conversion aborts it
    run(16'd65535, 2'd1, 16'hFFFF, 1'b1, "pre_abort");
    accept(16'd1234, 2'd0);
    repeat (5) tick();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(out_bcd, 16'h0000, "abort_bcd");
    check(16'(out_ovf), 16'd0, "abort_ovf");
    check(16'(in_ready), 16'd1, "abort_rdy");
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check(16'(pulses), 16'd0, "abort_valid");
    check(out_bcd, 16'h0000, "abort_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
